// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that merges keypad bytes (req 0, optionally prefixed) and host bytes
// (req 1) into a byte FIFO, then paces them into a start/busy UART serializer.
module uart_tx_scheduler #(
   parameter int         DEPTH      = 8,
   parameter logic [7:0] PREFIX0    = 8'h32,
   parameter bit         PREFIX0_EN = 1'b1,
   parameter int         GAP_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   req_valid,
   input  logic [15:0]                  req_data,
   output logic [1:0]                   req_ready,
   output logic [7:0]                   tx_data,
   output logic                         tx_start,
   input  logic                         tx_busy,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         overflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int TW    = $clog2(GAP_CYCLES + 2);
   localparam int NEED0 = PREFIX0_EN ? 2 : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_p1;
   logic [CW-1:0] count_q, free_w;
   logic [1:0]    ready_q;
   logic          rr_q;
   logic          ovf_q;

   logic [1:0]    want, room, elig, starve, grant;
   logic [1:0]    n_push;
   logic          launch, pop;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          start_d, tx_start_q;
   logic [7:0]    data_d, tx_data_q;

   // A requester in its ready cycle still shows valid, so it is masked out for that cycle.
   always_comb begin
      free_w = CW'(DEPTH) - count_q;
      want   = req_valid & ~ready_q;
      room   = {free_w != '0, free_w >= CW'(NEED0)};
      elig   = want & room;
      starve = want & ~room;
      grant  = elig;
      if (elig == 2'b11) grant = rr_q ? 2'b10 : 2'b01;
      n_push = 2'd0;
      if (grant[0])      n_push = 2'(NEED0);
      else if (grant[1]) n_push = 2'd1;
   end

   assign wr_p1  = wr_ptr_q + AW'(1);
   assign launch = (state_q == S_IDLE) && (count_q != '0) && !tx_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q  <= '0;
         rr_q     <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         ready_q  <= grant;
         if (|grant) rr_q <= grant[0];
         ovf_q    <= ovf_q | (|starve);
         wr_ptr_q <= wr_ptr_q + AW'(n_push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         count_q  <= count_q + CW'(n_push) - CW'(pop);
      end
   end

   // Prefix and keypad byte land in adjacent slots in one write, so nothing can interleave.
   always_ff @(posedge clk) begin
      if (grant[0]) begin
         if (PREFIX0_EN) begin
            mem_q[wr_ptr_q] <= PREFIX0;
            mem_q[wr_p1]    <= req_data[7:0];
         end else begin
            mem_q[wr_ptr_q] <= req_data[7:0];
         end
      end else if (grant[1]) begin
         mem_q[wr_ptr_q] <= req_data[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         tx_start_q <= start_d;
         tx_data_q  <= data_d;
      end
   end

   // WAIT_BUSY gives the serializer two cycles (including the start cycle) to answer.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_IDLE: begin
            if (launch) begin
               state_d = S_WAIT_BUSY;
               tmr_d   = '0;
            end
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (tmr_q == TW'(1)) begin
               state_d = S_GAP;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = S_GAP;
               tmr_d   = '0;
            end
         end
         S_GAP: begin
            if (tmr_q == TW'(GAP_CYCLES - 1)) state_d = S_IDLE;
            else                               tmr_d   = tmr_q + TW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop     = 1'b0;
      start_d = 1'b0;
      data_d  = tx_data_q;
      if (launch) begin
         pop     = 1'b1;
         start_d = 1'b1;
         data_d  = mem_q[rd_ptr_q];
      end
   end

   assign req_ready  = ready_q;
   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: cycle table for FIFO fill/overflow, plus sequences
// driven through small requester queues and a behavioural serializer.
module tb_uart_tx_scheduler;

   localparam int         DEPTH = 8;
   localparam int         GAP   = 16;
   localparam logic [7:0] PFX   = 8'h32;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [15:0] req_data  = '0;
   logic [1:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [3:0]  fifo_count;
   logic        overflow;

   uart_tx_scheduler #(
      .DEPTH(DEPTH), .PREFIX0(PFX), .PREFIX0_EN(1'b1), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Serializer model: mode 0 = busy ser_cyc cycles after each start, 1 = stuck busy, 2 = never busy
   int ser_mode = 0;
   int ser_cyc  = 10;
   int ser_cnt  = 0;
   always @(posedge clk) begin
      if (ser_mode == 0 && tx_start) ser_cnt <= ser_cyc;
      else if (ser_cnt > 0)          ser_cnt <= ser_cnt - 1;
   end
   assign tx_busy = (ser_mode == 1) || (ser_mode == 0 && ser_cnt > 0);

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [7:0] rq0[$];
   logic [7:0] rq1[$];
   logic [1:0] rdy_seen = '0;
   logic [7:0] tx_q[$];
   int         tx_t[$];
   int         g_q[$];
   int         max_cnt = 0;

   typedef struct {
      logic       rst;
      logic [1:0] vld;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] e_rdy;
      int         e_cnt;
      logic       e_ovf;
   } vec_t;
   vec_t tab[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [1:0] v, input logic [7:0] a,
                      input logic [7:0] b, input logic [1:0] er, input int ec, input logic eo);
      vec_t t;
      t.rst = r; t.vld = v; t.d0 = a; t.d1 = b; t.e_rdy = er; t.e_cnt = ec; t.e_ovf = eo;
      tab.push_back(t);
   endtask

   // One clock: sample the new cycle's outputs, then let the requesters react.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (rdy_seen[0] && rq0.size() > 0) rq0.delete(0);
      if (rdy_seen[1] && rq1.size() > 0) rq1.delete(0);
      if (tx_start) begin
         tx_q.push_back(tx_data);
         tx_t.push_back(cyc);
      end
      if (req_ready[0]) g_q.push_back(0);
      if (req_ready[1]) g_q.push_back(1);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      rdy_seen     = req_ready;
      req_valid    = {rq1.size() > 0, rq0.size() > 0};
      req_data     = 16'h0000;
      if (rq0.size() > 0) req_data[7:0]  = rq0[0];
      if (rq1.size() > 0) req_data[15:8] = rq1[0];
   endtask

   task automatic do_reset();
      rq0.delete();
      rq1.delete();
      rdy_seen = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int budget);
      for (int k = 0; k < budget && tx_q.size() < n; k++) step();
   endtask

   function automatic int txb(input int idx);
      if (idx >= 0 && idx < tx_q.size()) return int'(tx_q[idx]);
      return -1;
   endfunction

   function automatic int txc(input int idx);
      if (idx >= 0 && idx < tx_t.size()) return tx_t[idx];
      return -1000;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tb, gb, n0, c, n_g0, n_g1, k;

      // Reset state
      ser_mode = 1;
      do_reset();
      chk("reset.ready", int'(req_ready), 0);
      chk("reset.start", int'(tx_start), 0);
      chk("reset.data", int'(tx_data), 0);
      chk("reset.count", int'(fifo_count), 0);
      chk("reset.ovf", int'(overflow), 0);

      // Stuck-busy fill to DEPTH, refusal, then 7 used with req0 refused and req1 accepted
      add(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         add(1'b0, 2'b10, 8'h00, 8'(8'h40 + i), 2'b10, i + 1, 1'b0);
         add(1'b0, 2'b10, 8'h00, 8'(8'h40 + i), 2'b00, i + 1, 1'b0);
      end
      add(1'b0, 2'b10, 8'h00, 8'h48, 2'b00, 8, 1'b1);
      add(1'b0, 2'b10, 8'h00, 8'h48, 2'b00, 8, 1'b1);
      add(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         add(1'b0, 2'b10, 8'h00, 8'(8'h60 + i), 2'b10, i + 1, 1'b0);
         add(1'b0, 2'b10, 8'h00, 8'(8'h60 + i), 2'b00, i + 1, 1'b0);
      end
      add(1'b0, 2'b11, 8'h35, 8'h67, 2'b10, 8, 1'b1);
      add(1'b0, 2'b11, 8'h35, 8'h67, 2'b00, 8, 1'b1);

      for (int i = 0; i < tab.size(); i++) begin
         rst       = tab[i].rst;
         req_valid = tab[i].vld;
         req_data  = {tab[i].d1, tab[i].d0};
         @(posedge clk);
         #1;
         cyc++;
         chk($sformatf("tab[%0d].ready", i), int'(req_ready), int'(tab[i].e_rdy));
         chk($sformatf("tab[%0d].count", i), int'(fifo_count), tab[i].e_cnt);
         chk($sformatf("tab[%0d].ovf", i), int'(overflow), int'(tab[i].e_ovf));
         chk($sformatf("tab[%0d].start", i), int'(tx_start), 0);
      end
      rst = 1'b0;
      req_valid = '0;

      // Single keypad byte goes out as prefix then data, one grant pulse
      ser_mode = 0;
      ser_cyc  = 10;
      do_reset();
      tb = tx_q.size();
      gb = g_q.size();
      rq0.push_back(8'h35);
      wait_tx(tb + 2, 200);
      for (int i = 0; i < 20; i++) step();
      chk("t1.nbytes", tx_q.size() - tb, 2);
      chk("t1.byte0", txb(tb), 8'h32);
      chk("t1.byte1", txb(tb + 1), 8'h35);
      chk("t1.spacing_ok", int'((txc(tb + 1) - txc(tb)) >= 10 + GAP), 1);
      n_g0 = 0;
      n_g1 = 0;
      for (int i = gb; i < g_q.size(); i++) begin
         if (g_q[i] == 0) n_g0++;
         else             n_g1++;
      end
      chk("t1.ready0_pulses", n_g0, 1);
      chk("t1.ready1_pulses", n_g1, 0);

      // Both requesters always valid: grants alternate, prefix pairs stay intact
      do_reset();
      tb = tx_q.size();
      gb = g_q.size();
      rq0.push_back(8'hA0); rq0.push_back(8'hA1);
      rq1.push_back(8'hB0); rq1.push_back(8'hB1);
      wait_tx(tb + 6, 400);
      chk("t2.ngrants", g_q.size() - gb, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t2.grant%0d", i), (gb + i < g_q.size()) ? g_q[gb + i] : -1, i % 2);
      chk("t2.b0", txb(tb),     8'h32);
      chk("t2.b1", txb(tb + 1), 8'hA0);
      chk("t2.b2", txb(tb + 2), 8'hB0);
      chk("t2.b3", txb(tb + 3), 8'h32);
      chk("t2.b4", txb(tb + 4), 8'hA1);
      chk("t2.b5", txb(tb + 5), 8'hB1);

      // Full FIFO drains with refills; 3*DEPTH bytes exercise pointer wrap
      ser_mode = 1;
      do_reset();
      for (int i = 0; i < 3 * DEPTH; i++) rq1.push_back(8'(8'h80 + i));
      for (int i = 0; i < 40; i++) step();
      chk("t4.full_count", int'(fifo_count), DEPTH);
      chk("t4.full_ovf", int'(overflow), 1);
      tb = tx_q.size();
      max_cnt = 0;
      ser_mode = 0;
      ser_cyc  = 3;
      for (k = 0; k < 30 && fifo_count == 4'(DEPTH); k++) step();
      chk("t4.after_pop", int'(fifo_count), DEPTH - 1);
      step();
      chk("t4.refill", int'(fifo_count), DEPTH);
      wait_tx(tb + 3 * DEPTH, 1500);
      chk("t4.nbytes", tx_q.size() - tb, 3 * DEPTH);
      for (int i = 0; i < 3 * DEPTH; i++)
         chk($sformatf("t4.byte%0d", i), txb(tb + i), 8'h80 + i);
      chk("t4.max_count", max_cnt, DEPTH);
      chk("t4.drained", int'(fifo_count), 0);

      // Reset while the serializer is mid-frame with 4 bytes queued
      ser_cyc = 60;
      tb = tx_q.size();
      for (int i = 0; i < 5; i++) rq1.push_back(8'(8'hC0 + i));
      wait_tx(tb + 1, 100);
      for (k = 0; k < 40 && !(fifo_count == 4'd4 && tx_busy); k++) step();
      chk("t5.queued4_busy", int'(fifo_count == 4'd4 && tx_busy), 1);
      chk("t5.pre_ovf", int'(overflow), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5.count", int'(fifo_count), 0);
      chk("t5.start", int'(tx_start), 0);
      chk("t5.ovf", int'(overflow), 0);
      chk("t5.ready", int'(req_ready), 0);
      n0 = tx_q.size();
      for (k = 0; k < 100 && tx_busy; k++) step();
      chk("t5.busy_fell", int'(tx_busy), 0);
      for (int i = 0; i < 5; i++) step();
      chk("t5.no_start", tx_q.size() - n0, 0);
      rq1.push_back(8'h77);
      step();
      c = cyc;
      wait_tx(n0 + 1, 20);
      chk("t5.new_byte", txb(n0), 8'h77);
      chk("t5.latency", txc(n0) - c, 2);

      // Serializer never answers: two WAIT_BUSY cycles, GAP, then IDLE issues the next start
      ser_mode = 2;
      do_reset();
      tb = tx_q.size();
      rq1.push_back(8'hD0);
      rq1.push_back(8'hD1);
      wait_tx(tb + 2, 100);
      chk("t6.b0", txb(tb), 8'hD0);
      chk("t6.b1", txb(tb + 1), 8'hD1);
      chk("t6.spacing", txc(tb + 1) - txc(tb), GAP + 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
